// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared opcodes, control-bundle layout, exception causes and FSM
//            state encoding for the pipelined control unit.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LB    = 6'd32;
  localparam logic [5:0] OP_LH    = 6'd33;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_LBU   = 6'd36;
  localparam logic [5:0] OP_LHU   = 6'd37;
  localparam logic [5:0] OP_SB    = 6'd40;
  localparam logic [5:0] OP_SH    = 6'd41;
  localparam logic [5:0] OP_SW    = 6'd43;

  // Bundle widths
  localparam int EXE_W = 4;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  // Bundle bit positions: exe={ALUop[1:0],ALUsrc,RegDst}
  localparam int EXE_REGDST = 0;
  localparam int EXE_ALUSRC = 1;
  localparam int EXE_ALUOP  = 2;
  // mem={Branch,MemWrite,MemRead}
  localparam int MEM_MEMREAD  = 0;
  localparam int MEM_MEMWRITE = 1;
  localparam int MEM_BRANCH   = 2;
  // wb={Mem2Reg,RegWrite}
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEM2REG  = 1;

  // Bundle values per instruction class
  localparam logic [EXE_W-1:0] EXE_R   = 4'b1001;
  localparam logic [EXE_W-1:0] EXE_IMM = 4'b1010;
  localparam logic [EXE_W-1:0] EXE_LS  = 4'b0010;
  localparam logic [EXE_W-1:0] EXE_BR  = 4'b0100;
  localparam logic [MEM_W-1:0] MEM_LD  = 3'b001;
  localparam logic [MEM_W-1:0] MEM_ST  = 3'b010;
  localparam logic [MEM_W-1:0] MEM_BR  = 3'b100;
  localparam logic [WB_W-1:0]  WB_ALU  = 2'b01;
  localparam logic [WB_W-1:0]  WB_LD   = 2'b11;

  // Exception causes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_RZERO   = 2'b10;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Purpose  : Combinational opcode -> control bundle + exception cause decode
//            for the ID stage. Also reports whether rt is a source operand.
// Config   : CTRL_JUMP_EN - decode j/jal as legal and drive jump_o.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int RZERO_EXC = 1
) (
`ifdef CTRL_JUMP_EN
  output logic             jump_o,
`endif
  input  logic [5:0]       op_i,
  input  logic [4:0]       rt_i,
  input  logic [4:0]       rd_i,
  output logic [EXE_W-1:0] exe_o,
  output logic [MEM_W-1:0] mem_o,
  output logic [WB_W-1:0]  wb_o,
  output logic [1:0]       cause_o,
  output logic             uses_rt_o
);

  logic w_wr_zero;

  // Opcode table; illegal opcodes leave the bundle at zero.
  always_comb begin
    exe_o     = '0;
    mem_o     = '0;
    wb_o      = '0;
    cause_o   = CAUSE_NONE;
    uses_rt_o = 1'b0;
    w_wr_zero = 1'b0;
`ifdef CTRL_JUMP_EN
    jump_o    = 1'b0;
`endif
    case (op_i)
      OP_RTYPE: begin
        exe_o     = EXE_R;
        wb_o      = WB_ALU;
        uses_rt_o = 1'b1;
        w_wr_zero = (rd_i == 5'd0);
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        exe_o     = EXE_IMM;
        wb_o      = WB_ALU;
        w_wr_zero = (rt_i == 5'd0);
      end
      OP_SLTI, OP_SLTIU: begin
        exe_o = EXE_IMM;
        wb_o  = WB_ALU;
      end
      OP_LB, OP_LW: begin
        exe_o     = EXE_LS;
        mem_o     = MEM_LD;
        wb_o      = WB_LD;
        w_wr_zero = (rt_i == 5'd0);
      end
      OP_LH, OP_LBU, OP_LHU: begin
        exe_o = EXE_LS;
        mem_o = MEM_LD;
        wb_o  = WB_LD;
      end
      OP_SB, OP_SH, OP_SW: begin
        exe_o     = EXE_LS;
        mem_o     = MEM_ST;
        uses_rt_o = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        exe_o     = EXE_BR;
        mem_o     = MEM_BR;
        uses_rt_o = 1'b1;
      end
`ifdef CTRL_JUMP_EN
      OP_J: begin
        jump_o = 1'b1;
      end
      OP_JAL: begin
        jump_o = 1'b1;
        wb_o   = WB_ALU;   // writes $31, never $0
      end
`endif
      default: begin
        cause_o = CAUSE_ILLEGAL;
      end
    endcase
    if ((RZERO_EXC != 0) && w_wr_zero) begin
      cause_o = CAUSE_RZERO;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Purpose  : ID-stage decode plus ID/EX, EX/MEM, MEM/WB control registers,
//            load-use stall, branch flush and precise-exception FSM
//            (RUN -> DRAIN -> HALT -> RUN on acknowledge).
// Config   : CTRL_JUMP_EN - adds j/jal decode and the id_jump_o output.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int RZERO_EXC = 1,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_instr_i,
  input  logic             id_valid_i,
  input  logic [PC_W-1:0]  id_pc_i,
  input  logic             branch_taken_i,
  input  logic             exc_ack_i,
`ifdef CTRL_JUMP_EN
  output logic             id_jump_o,
`endif
  output logic [EXE_W-1:0] ex_exe_o,
  output logic [MEM_W-1:0] mem_mem_o,
  output logic [WB_W-1:0]  wb_wb_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic             exc_req_o,
  output logic [PC_W-1:0]  exc_pc_o,
  output logic [1:0]       exc_cause_o
);

  localparam int              CNT_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYC - 1);

  // Instruction fields
  logic [5:0] w_op;
  logic [4:0] w_rs, w_rt, w_rd;
  logic       unused_instr_bits;
  assign w_op = id_instr_i[31:26];
  assign w_rs = id_instr_i[25:21];
  assign w_rt = id_instr_i[20:16];
  assign w_rd = id_instr_i[15:11];
  assign unused_instr_bits = ^id_instr_i[10:0];

  logic [EXE_W-1:0] w_exe;
  logic [MEM_W-1:0] w_mem;
  logic [WB_W-1:0]  w_wb;
  logic [1:0]       w_cause;
  logic             w_uses_rt;

  ctrl_decode #(
    .RZERO_EXC (RZERO_EXC)
  ) u_decode (
`ifdef CTRL_JUMP_EN
    .jump_o    (id_jump_o),
`endif
    .op_i      (w_op),
    .rt_i      (w_rt),
    .rd_i      (w_rd),
    .exe_o     (w_exe),
    .mem_o     (w_mem),
    .wb_o      (w_wb),
    .cause_o   (w_cause),
    .uses_rt_o (w_uses_rt)
  );

  // Stage registers
  logic [EXE_W-1:0] ex_exe_q;
  logic [MEM_W-1:0] ex_mem_q;
  logic [WB_W-1:0]  ex_wb_q;
  logic [4:0]       ex_rt_q;
  logic [MEM_W-1:0] mem_mem_q;
  logic [WB_W-1:0]  mem_wb_q;
  logic [WB_W-1:0]  wb_wb_q;

  // FSM and exception capture
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  exc_pc_q;
  logic [1:0]       exc_cause_q;

  logic w_load_use, w_flush, w_stall, w_raise, w_exc_req, w_id_kill;

  // Load in EX whose destination is a source of the ID instruction.
  assign w_load_use = id_valid_i && ex_mem_q[MEM_MEMREAD] && (ex_rt_q != 5'd0) &&
                      ((ex_rt_q == w_rs) || (w_uses_rt && (ex_rt_q == w_rt)));
  assign w_flush    = branch_taken_i;

  // Next-state and stall/raise decisions; flush wins over stall and raise in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_stall   = 1'b0;
    w_raise   = 1'b0;
    w_exc_req = 1'b0;
    case (state_q)
      RUN: begin
        w_stall = w_load_use && !w_flush;
        w_raise = id_valid_i && !w_flush && !w_load_use && (w_cause != CAUSE_NONE);
        if (w_raise) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        w_stall = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = HALT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HALT: begin
        w_stall   = 1'b1;
        w_exc_req = 1'b1;
        if (exc_ack_i) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // A zero bundle enters EX for bubbles, flushes, stalls and the excepting instruction.
  assign w_id_kill = !id_valid_i || w_flush || w_stall || w_raise;

  // FSM state and drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pipeline control registers ID->EX->MEM->WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_exe_q  <= '0;
      ex_mem_q  <= '0;
      ex_wb_q   <= '0;
      ex_rt_q   <= '0;
      mem_mem_q <= '0;
      mem_wb_q  <= '0;
      wb_wb_q   <= '0;
    end else begin
      wb_wb_q <= mem_wb_q;
      if (w_flush) begin
        ex_exe_q  <= '0;
        ex_mem_q  <= '0;
        ex_wb_q   <= '0;
        ex_rt_q   <= '0;
        mem_mem_q <= '0;
        mem_wb_q  <= '0;
      end else begin
        mem_mem_q <= ex_mem_q;
        mem_wb_q  <= ex_wb_q;
        if (w_id_kill) begin
          ex_exe_q <= '0;
          ex_mem_q <= '0;
          ex_wb_q  <= '0;
          ex_rt_q  <= '0;
        end else begin
          ex_exe_q <= w_exe;
          ex_mem_q <= w_mem;
          ex_wb_q  <= w_wb;
          ex_rt_q  <= w_rt;
        end
      end
    end
  end

  // Capture PC and cause of the excepting instruction; held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_pc_q    <= '0;
      exc_cause_q <= CAUSE_NONE;
    end else if (w_raise) begin
      exc_pc_q    <= id_pc_i;
      exc_cause_q <= w_cause;
    end
  end

  assign ex_exe_o    = ex_exe_q;
  assign mem_mem_o   = mem_mem_q;
  assign wb_wb_o     = wb_wb_q;
  assign stall_o     = w_stall;
  assign flush_o     = w_flush;
  assign exc_req_o   = w_exc_req;
  assign exc_pc_o    = exc_pc_q;
  assign exc_cause_o = exc_cause_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Purpose  : Directed scoreboard bench for pipe_ctrl_unit; a second instance
//            with RZERO_EXC=0 shares the stimulus.
// Config   : CTRL_JUMP_EN - exercises id_jump_o and legal jal decode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

  localparam int S_EXE = 0, S_MEM = 1, S_WB = 2, S_STALL = 3, S_FLUSH = 4,
                 S_REQ = 5, S_PC = 6, S_CAUSE = 7, S_WB0 = 8, S_REQ0 = 9, S_JUMP = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] id_instr = '0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0;
  logic        br = 1'b0;
  logic        ack = 1'b0;

  logic [3:0]  ex_exe, ex_exe0;
  logic [2:0]  mem_mem, mem_mem0;
  logic [1:0]  wb_wb, wb_wb0;
  logic        stall, stall0, flush, flush0, req, req0;
  logic [31:0] exc_pc, exc_pc0;
  logic [1:0]  cause, cause0;
`ifdef CTRL_JUMP_EN
  logic        jump, jump0;
`endif

  pipe_ctrl_unit u_dut (
    .clk(clk), .rst_n(rst_n), .id_instr_i(id_instr), .id_valid_i(id_valid),
    .id_pc_i(id_pc), .branch_taken_i(br), .exc_ack_i(ack),
`ifdef CTRL_JUMP_EN
    .id_jump_o(jump),
`endif
    .ex_exe_o(ex_exe), .mem_mem_o(mem_mem), .wb_wb_o(wb_wb), .stall_o(stall),
    .flush_o(flush), .exc_req_o(req), .exc_pc_o(exc_pc), .exc_cause_o(cause)
  );

  pipe_ctrl_unit #(.RZERO_EXC(0)) u_dut_nz (
    .clk(clk), .rst_n(rst_n), .id_instr_i(id_instr), .id_valid_i(id_valid),
    .id_pc_i(id_pc), .branch_taken_i(br), .exc_ack_i(ack),
`ifdef CTRL_JUMP_EN
    .id_jump_o(jump0),
`endif
    .ex_exe_o(ex_exe0), .mem_mem_o(mem_mem0), .wb_wb_o(wb_wb0), .stall_o(stall0),
    .flush_o(flush0), .exc_req_o(req0), .exc_pc_o(exc_pc0), .exc_cause_o(cause0)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] get_sig(input int s);
    case (s)
      S_EXE:   return {28'd0, ex_exe};
      S_MEM:   return {29'd0, mem_mem};
      S_WB:    return {30'd0, wb_wb};
      S_STALL: return {31'd0, stall};
      S_FLUSH: return {31'd0, flush};
      S_REQ:   return {31'd0, req};
      S_PC:    return exc_pc;
      S_CAUSE: return {30'd0, cause};
      S_WB0:   return {30'd0, wb_wb0};
      S_REQ0:  return {31'd0, req0};
`ifdef CTRL_JUMP_EN
      S_JUMP:  return {31'd0, jump};
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_at(input string tag, input int sig, input logic [31:0] v, input int lat);
    exp_t e;
    e.tag = tag; e.sig = sig; e.exp = v; e.due = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic check_due();
    logic [31:0] obs;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        obs = get_sig(sb[i].sig);
        n_tests++;
        assert (obs === sb[i].exp) else begin
          n_fail++;
          $error("FAIL %s (cycle %0d): observed %0h expected %0h", sb[i].tag, cyc, obs, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  endtask

  // Drive one ID cycle, check what is due mid-cycle, then advance past the edge.
  task automatic step(input logic [31:0] instr, input logic v, input logic [31:0] pc,
                      input logic b, input logic a);
    id_instr = instr; id_valid = v; id_pc = pc; br = b; ack = a;
    #3;
    check_due();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) step(32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic expect_all_zero(input string tag);
    expect_at({tag, "_exe"},   S_EXE,   32'd0, 0);
    expect_at({tag, "_mem"},   S_MEM,   32'd0, 0);
    expect_at({tag, "_wb"},    S_WB,    32'd0, 0);
    expect_at({tag, "_stall"}, S_STALL, 32'd0, 0);
    expect_at({tag, "_flush"}, S_FLUSH, 32'd0, 0);
    expect_at({tag, "_req"},   S_REQ,   32'd0, 0);
    expect_at({tag, "_pc"},    S_PC,    32'd0, 0);
    expect_at({tag, "_cause"}, S_CAUSE, 32'd0, 0);
  endtask

  logic [31:0] LW, ADD, BEQ, ILL, ADDI0, JAL;

  initial begin
    LW    = itype(6'd35, 5'd1, 5'd2, 16'd0);
    ADD   = rtype(5'd2, 5'd4, 5'd3);
    BEQ   = itype(6'd4, 5'd1, 5'd2, 16'd8);
    ILL   = {6'd63, 26'd0};
    ADDI0 = itype(6'd8, 5'd1, 5'd0, 16'd5);
    JAL   = {6'd3, 26'd0};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    expect_all_zero("rst");
    check_due();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load-use hazard: lw $2 then add $3,$2,$4
    expect_at("lw_nostall", S_STALL, 32'd0, 0);
    expect_at("lw_exe",     S_EXE,   32'h2, 1);
    expect_at("lw_mem",     S_MEM,   32'h1, 2);
    expect_at("lw_wb",      S_WB,    32'h3, 3);
    step(LW, 1'b1, 32'h10, 1'b0, 1'b0);
    expect_at("lu_stall",   S_STALL, 32'd1, 0);
    expect_at("lu_bubble",  S_EXE,   32'h0, 1);
    step(ADD, 1'b1, 32'h14, 1'b0, 1'b0);
    expect_at("lu_release", S_STALL, 32'd0, 0);
    expect_at("add_exe",    S_EXE,   32'h9, 1);
    expect_at("add_wb",     S_WB,    32'h1, 3);
    step(ADD, 1'b1, 32'h14, 1'b0, 1'b0);

    // Taken branch in MEM flushes an illegal opcode in ID
    expect_at("beq_mem", S_MEM, 32'h4, 2);
    step(BEQ, 1'b1, 32'h20, 1'b0, 1'b0);
    nop(1);
    expect_at("br_flush",     S_FLUSH, 32'd1, 0);
    expect_at("br_nostall",   S_STALL, 32'd0, 0);
    expect_at("br_ex_zero",   S_EXE,   32'd0, 1);
    expect_at("br_mem_zero",  S_MEM,   32'd0, 1);
    expect_at("br_nodrain1",  S_STALL, 32'd0, 1);
    expect_at("br_nodrain2",  S_STALL, 32'd0, 2);
    expect_at("br_noreq",     S_REQ,   32'd0, 4);
    step(ILL, 1'b1, 32'h28, 1'b1, 1'b0);
    nop(5);

    // Illegal opcode at 0x40: drain, halt, acknowledge
    expect_at("ill_nostall",  S_STALL, 32'd0, 0);
    expect_at("ill_squash",   S_EXE,   32'd0, 1);
    expect_at("drain_stall",  S_STALL, 32'd1, 1);
    expect_at("drain_noreq",  S_REQ,   32'd0, 3);
    expect_at("halt_req",     S_REQ,   32'd1, 4);
    expect_at("halt_pc",      S_PC,    32'h40, 4);
    expect_at("halt_cause",   S_CAUSE, 32'h1, 4);
    expect_at("halt_stall",   S_STALL, 32'd1, 5);
    step(ILL, 1'b1, 32'h40, 1'b0, 1'b0);
    nop(1);
    step(32'd0, 1'b0, 32'd0, 1'b0, 1'b1);   // ack during DRAIN is ignored
    nop(3);
    expect_at("ack_req_drop", S_REQ,   32'd0, 1);
    expect_at("ack_pc_hold",  S_PC,    32'h40, 1);
    expect_at("ack_run",      S_STALL, 32'd0, 1);
    step(32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    nop(1);

    // addi $0,$1,5: cause 10 with RZERO_EXC=1, plain write with RZERO_EXC=0
    expect_at("rz_wb_squash", S_WB,    32'd0, 3);
    expect_at("rz_req",       S_REQ,   32'd1, 4);
    expect_at("rz_cause",     S_CAUSE, 32'h2, 4);
    expect_at("rz_pc",        S_PC,    32'h50, 4);
    expect_at("nz_wb",        S_WB0,   32'h1, 3);
    expect_at("nz_noreq",     S_REQ0,  32'd0, 4);
    step(ADDI0, 1'b1, 32'h50, 1'b0, 1'b0);
    nop(4);
    expect_at("rz_ack", S_REQ, 32'd0, 1);
    step(32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    nop(1);

    // Asynchronous reset during DRAIN
    step(ILL, 1'b1, 32'h60, 1'b0, 1'b0);
    nop(1);
    id_instr = 32'd0; id_valid = 1'b0; id_pc = 32'd0; br = 1'b0; ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    expect_all_zero("arst");
    check_due();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    expect_at("post_rst_stall", S_STALL, 32'd0, 0);
    expect_at("post_rst_exe",   S_EXE,   32'h2, 1);
    expect_at("post_rst_mem",   S_MEM,   32'h1, 2);
    expect_at("post_rst_noreq", S_REQ,   32'd0, 4);
    step(LW, 1'b1, 32'h64, 1'b0, 1'b0);
    nop(5);

    // jal
`ifdef CTRL_JUMP_EN
    expect_at("jal_jump",  S_JUMP, 32'd1, 0);
    expect_at("jal_wb",    S_WB,   32'h1, 3);
    expect_at("jal_noreq", S_REQ,  32'd0, 4);
    step(JAL, 1'b1, 32'h70, 1'b0, 1'b0);
    nop(5);
`else
    expect_at("jal_req",   S_REQ,   32'd1, 4);
    expect_at("jal_cause", S_CAUSE, 32'h1, 4);
    expect_at("jal_pc",    S_PC,    32'h70, 4);
    step(JAL, 1'b1, 32'h70, 1'b0, 1'b0);
    nop(4);
    step(32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    nop(1);
`endif

    // Drain anything still outstanding, bounded
    for (int g = 0; g < 20 && sb.size() > 0; g++) nop(1);
    while (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never reached its due cycle %0d", sb[0].tag, sb[0].due);
      sb.delete(0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
